zoom_copy_sequencer: RTL and testbench



---
 rtl/zoom_pkg.sv | 35 +++
 rtl/zoom_addr_gen.sv | 87 ++++++++
 rtl/zoom_copy_sequencer.sv | 154 +++++++++++++++
 tb/tb_zoom_copy_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zoom_pkg.sv
// Shared definitions for the zoom copy sequencer: mode encodings,
// destination geometry helpers and the sequencer state enum.
package zoom_pkg;

    localparam logic [1:0] ZOOM_X2   = 2'b00;
    localparam logic [1:0] ZOOM_HALF = 2'b01;
    localparam logic [1:0] ZOOM_1X   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN,
        WAIT_VB
    } state_t;

    // Destination width for a zoom mode given the source width
    function automatic int dest_w(input logic [1:0] mode, input int src_w);
        case (mode)
            ZOOM_X2:   return 2 * src_w;
            ZOOM_HALF: return src_w / 2;
            default:   return src_w;
        endcase
    endfunction

    // Destination height for a zoom mode given the source height
    function automatic int dest_h(input logic [1:0] mode, input int src_h);
        case (mode)
            ZOOM_X2:   return 2 * src_h;
            ZOOM_HALF: return src_h / 2;
            default:   return src_h;
        endcase
    endfunction

endpackage

// File: rtl/zoom_addr_gen.sv
// Address generator: walks destination pixels in raster order and keeps
// the nearest-neighbour source address with row-base accumulators, so no
// multiplier sits in the per-pixel loop. Outputs are the addresses of the
// pixel currently being presented.
module zoom_addr_gen
    import zoom_pkg::*;
#(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] src_addr,
    output logic [ADDR_W-1:0] dst_addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] dx;
    logic [ADDR_W-1:0] dy;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] dw;
    logic [ADDR_W-1:0] dh;
    logic [ADDR_W-1:0] col_step;
    logic [ADDR_W-1:0] row_step;
    logic              row_end;

    assign dw      = ADDR_W'(dest_w(mode, SRC_W));
    assign dh      = ADDR_W'(dest_h(mode, SRC_H));
    assign row_end = (dx == dw - ONE);
    assign last    = row_end && (dy == dh - ONE);

    // Per-mode source increments: x2 repeats each source pixel and row,
    // /2 skips every other one, 1:1 steps straight through.
    always_comb begin
        col_step = ONE;
        row_step = ADDR_W'(SRC_W);
        case (mode)
            ZOOM_X2: begin
                col_step = {{(ADDR_W-1){1'b0}}, dx[0]};
                row_step = dy[0] ? ADDR_W'(SRC_W) : '0;
            end
            ZOOM_HALF: begin
                col_step = ADDR_W'(2);
                row_step = ADDR_W'(2 * SRC_W);
            end
            default: begin
                col_step = ONE;
                row_step = ADDR_W'(SRC_W);
            end
        endcase
    end

    // Raster counters, source row base and linear destination counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dx       <= '0;
            dy       <= '0;
            row_base <= '0;
            src_addr <= '0;
            dst_addr <= '0;
        end else if (clear) begin
            dx       <= '0;
            dy       <= '0;
            row_base <= '0;
            src_addr <= '0;
            dst_addr <= '0;
        end else if (advance && !last) begin
            dst_addr <= dst_addr + ONE;
            if (row_end) begin
                dx       <= '0;
                dy       <= dy + ONE;
                row_base <= row_base + row_step;
                src_addr <= row_base + row_step;
            end else begin
                dx       <= dx + ONE;
                src_addr <= src_addr + col_step;
            end
        end
    end

endmodule

// File: rtl/zoom_copy_sequencer.sv
// ROM-to-framebuffer copy sequencer for the zoom display path.
// Issues one source read per cycle, carries a valid/destination pipeline
// matching the ROM read latency, and registers the RAM write port.
// Optional: define ZOOM_COPY_VBLANK_SYNC_EN to add a vblank input; an
// accepted start then waits for vblank before issuing reads.
module zoom_copy_sequencer
    import zoom_pkg::*;
#(
    parameter int SRC_W   = 160,
    parameter int SRC_H   = 120,
    parameter int ROM_LAT = 2,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              start,
`ifdef ZOOM_COPY_VBLANK_SYNC_EN
    input  logic              vblank,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done
);

    state_t             state;
    state_t             state_next;
    logic [1:0]         mode_q;
    logic               done_q;
    logic [2:0]         drain_cnt;
    logic               issue;
    logic               last;
    logic [ADDR_W-1:0]  dst_addr;
    logic [ROM_LAT-1:0] vld_p;
    logic [ADDR_W-1:0]  wa_p [ROM_LAT];

    zoom_addr_gen #(
        .SRC_W  (SRC_W),
        .SRC_H  (SRC_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (start),
        .advance  (issue),
        .mode     (mode_q),
        .src_addr (rom_addr),
        .dst_addr (dst_addr),
        .last     (last)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and decoded controls; start wins in every state
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        busy       = 1'b0;
        case (state)
            ISSUE:   busy = 1'b1;
            DRAIN:   busy = 1'b1;
            WAIT_VB: busy = 1'b1;
            default: busy = 1'b0;
        endcase
        if (start) begin
`ifdef ZOOM_COPY_VBLANK_SYNC_EN
            state_next = WAIT_VB;
`else
            state_next = ISSUE;
`endif
        end else begin
            case (state)
                IDLE: state_next = IDLE;
`ifdef ZOOM_COPY_VBLANK_SYNC_EN
                WAIT_VB: if (vblank) state_next = ISSUE;
`endif
                ISSUE: begin
                    issue = 1'b1;
                    if (last) state_next = DRAIN;
                end
                DRAIN: if (drain_cnt == 3'(ROM_LAT)) state_next = FIN;
                FIN:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Drain length counter, runs only while flushing the read pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               drain_cnt <= '0;
        else if (state != DRAIN) drain_cnt <= '0;
        else                     drain_cnt <= drain_cnt + 3'd1;
    end

    // Mode latch and sticky done flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= ZOOM_1X;
            done_q <= 1'b0;
        end else if (start) begin
            mode_q <= mode;
            done_q <= 1'b0;
        end else if (state_next == FIN) begin
            done_q <= 1'b1;
        end
    end

    assign done = done_q;

    // Read-valid shift register; a start flushes in-flight reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p <= '0;
        end else if (start) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < ROM_LAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Destination address travels alongside its read
    always_ff @(posedge clk) begin
        wa_p[0] <= dst_addr;
        for (int i = 1; i < ROM_LAT; i++) wa_p[i] <= wa_p[i-1];
    end

    // RAM write port; data and address hold between writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_wren   <= 1'b0;
            ram_data   <= '0;
            ram_wraddr <= '0;
        end else if (start) begin
            ram_wren <= 1'b0;
        end else begin
            ram_wren <= vld_p[ROM_LAT-1];
            if (vld_p[ROM_LAT-1]) begin
                ram_data   <= rom_data;
                ram_wraddr <= wa_p[ROM_LAT-1];
            end
        end
    end

endmodule

// File: tb/tb_zoom_copy_sequencer.sv
// Directed bench for zoom_copy_sequencer with a small source image.
module tb_zoom_copy_sequencer;

    localparam int SRC_W   = 64;
    localparam int SRC_H   = 48;
    localparam int ROM_LAT = 2;
    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 8;
`ifdef ZOOM_COPY_VBLANK_SYNC_EN
    localparam int VB_EXTRA = 1;
`else
    localparam int VB_EXTRA = 0;
`endif
    localparam int N1  = SRC_W * SRC_H;
    localparam int DW2 = 2 * SRC_W;
    localparam int N2  = 4 * N1;
    localparam int DWH = SRC_W / 2;
    localparam int NH  = (SRC_W / 2) * (SRC_H / 2);
    localparam int HALF_LAST_SRC = (2 * (SRC_H / 2 - 1)) * SRC_W + 2 * (SRC_W / 2 - 1);

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        mode;
    logic              start;
`ifdef ZOOM_COPY_VBLANK_SYNC_EN
    logic              vblank;
`endif
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [ADDR_W-1:0] ram_wraddr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_bad = 0;
    int ticks = 0;
    int wcnt  = 0;
    int first_wa = -1;
    int first_tick = -1;
    int lat;
    int snap;
    logic              flag;
    logic [ADDR_W-1:0] last_wa;
    logic [DATA_W-1:0] last_wd;
    logic [DATA_W-1:0] wmem [0:16383];
    logic [ADDR_W-1:0] rp [ROM_LAT];

    zoom_copy_sequencer #(
        .SRC_W   (SRC_W),
        .SRC_H   (SRC_H),
        .ROM_LAT (ROM_LAT),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .start      (start),
`ifdef ZOOM_COPY_VBLANK_SYNC_EN
        .vblank     (vblank),
`endif
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ram_wraddr (ram_wraddr),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .busy       (busy),
        .done       (done)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    // ROM model with ROM_LAT cycles of read latency
    always @(posedge clk) begin
        rp[0] <= rom_addr;
        for (int i = 1; i < ROM_LAT; i++) rp[i] <= rp[i-1];
    end
    assign rom_data = rom_f(rp[ROM_LAT-1]);

    function automatic logic [31:0] rd(input int a);
        return 32'(wmem[a[13:0]]);
    endfunction

    function automatic logic [31:0] rom_x(input int a);
        return 32'(rom_f(ADDR_W'(a)));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ticks++;
        if (ram_wren) begin
            wmem[ram_wraddr[13:0]] = ram_data;
            wcnt++;
            last_wa = ram_wraddr;
            last_wd = ram_data;
            if (first_wa < 0) begin
                first_wa   = int'(ram_wraddr);
                first_tick = ticks;
            end
        end
    endtask

    task automatic begin_copy(input logic [1:0] m);
        for (int i = 0; i < 16384; i++) wmem[i] = 'x;
        wcnt = 0;
        first_wa = -1;
        first_tick = -1;
        ticks = 0;
        mode = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget, output int n);
        while (!done && ticks < budget) tick();
        chk("done_within_budget", 32'(done), 32'd1);
        n = ticks;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 2'b10;
`ifdef ZOOM_COPY_VBLANK_SYNC_EN
        vblank = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_wren", 32'(ram_wren), 32'd0);
        chk("rst_wraddr", 32'(ram_wraddr), 32'd0);
        chk("rst_data", 32'(ram_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        // 1:1 copy
        begin_copy(2'b10);
        chk("1x_busy", 32'(busy), 32'd1);
        chk("1x_done_low", 32'(done), 32'd0);
        repeat (1 + VB_EXTRA) tick();
        chk("1x_rom_addr_step", 32'(rom_addr), 32'd1);
        run_to_done(N1 + 100, lat);
        chk("1x_latency", 32'(lat), 32'(N1 + ROM_LAT + 2 + VB_EXTRA));
        chk("1x_first_tick", 32'(first_tick), 32'(ROM_LAT + 2 + VB_EXTRA));
        chk("1x_first_wa", 32'(first_wa), 32'd0);
        chk("1x_wcnt", 32'(wcnt), 32'(N1));
        chk("1x_px0", rd(0), rom_x(0));
        chk("1x_row1", rd(SRC_W), rom_x(SRC_W));
        chk("1x_last_wa", 32'(last_wa), 32'(N1 - 1));
        chk("1x_last_wd", 32'(last_wd), rom_x(N1 - 1));
        chk("1x_fin_busy", 32'(busy), 32'd0);
        tick();
        chk("1x_done_hold", 32'(done), 32'd1);
        chk("1x_idle_wren", 32'(ram_wren), 32'd0);
        chk("1x_idle_wa_hold", 32'(ram_wraddr), 32'(N1 - 1));

        // Restart a 1:1 copy with x2 partway through
        begin_copy(2'b10);
        repeat (1000) tick();
        begin_copy(2'b00);
        run_to_done(N2 + 100, lat);
        chk("x2_first_wa", 32'(first_wa), 32'd0);
        chk("x2_first_tick", 32'(first_tick), 32'(ROM_LAT + 2 + VB_EXTRA));
        chk("x2_latency", 32'(lat), 32'(N2 + ROM_LAT + 2 + VB_EXTRA));
        chk("x2_wcnt", 32'(wcnt), 32'(N2));
        chk("x2_px0", rd(0), rom_x(0));
        chk("x2_px1", rd(1), rom_x(0));
        chk("x2_pxdw", rd(DW2), rom_x(0));
        chk("x2_pxdw1", rd(DW2 + 1), rom_x(0));
        chk("x2_px2", rd(2), rom_x(1));
        chk("x2_row2", rd(2 * DW2), rom_x(SRC_W));
        chk("x2_last_wa", 32'(last_wa), 32'(N2 - 1));
        chk("x2_last_wd", 32'(last_wd), rom_x(N1 - 1));

        // Half-size copy
        begin_copy(2'b01);
        run_to_done(NH + 100, lat);
        chk("half_latency", 32'(lat), 32'(NH + ROM_LAT + 2 + VB_EXTRA));
        chk("half_wcnt", 32'(wcnt), 32'(NH));
        chk("half_px1", rd(1), rom_x(2));
        chk("half_row1", rd(DWH), rom_x(2 * SRC_W));
        chk("half_last_wa", 32'(last_wa), 32'(NH - 1));
        chk("half_last_wd", 32'(last_wd), rom_x(HALF_LAST_SRC));

        // Reset in the middle of a copy
        begin_copy(2'b10);
        repeat (100) tick();
        reset = 1'b1;
        #1;
        chk("midrst_wren", 32'(ram_wren), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
        tick();
        reset = 1'b0;
        snap = wcnt;
        repeat (30) tick();
        chk("midrst_no_writes", 32'(wcnt), 32'(snap));
        chk("midrst_idle_busy", 32'(busy), 32'd0);

`ifdef ZOOM_COPY_VBLANK_SYNC_EN
        // Start waits for vblank; a restart while waiting re-latches mode
        vblank = 1'b0;
        begin_copy(2'b10);
        flag = 1'b0;
        repeat (25) begin
            tick();
            if (!busy || rom_addr != '0) flag = 1'b1;
        end
        mode = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (25) begin
            tick();
            if (!busy || rom_addr != '0) flag = 1'b1;
        end
        chk("vb_wait_hold", 32'(flag), 32'd0);
        chk("vb_wait_no_writes", 32'(wcnt), 32'd0);
        vblank = 1'b1;
        tick();
        chk("vb_first_issue_addr", 32'(rom_addr), 32'd0);
        tick();
        chk("vb_second_issue_addr", 32'(rom_addr), 32'd2);
        run_to_done(NH + 200, lat);
        chk("vb_wcnt", 32'(wcnt), 32'(NH));
        chk("vb_last_wa", 32'(last_wa), 32'(NH - 1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
